// File: rtl/seq_chunk_adder_if.sv
// Handshake and operand/result bundle for seq_chunk_adder.
// The master drives the request side; the slave (the adder) drives the results.
interface seq_chunk_adder_if #(
    parameter int WIDTH = 32
) ();
    logic             start;
    logic             sub;
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] resadder;
    logic             cout;
    logic             overflow;

    modport master (
        output start, sub, x, y, cin,
        input  busy, done, resadder, cout, overflow
    );

    modport slave (
        input  start, sub, x, y, cin,
        output busy, done, resadder, cout, overflow
    );
endinterface

// File: rtl/seq_chunk_adder.sv
// Multi-cycle add/subtract engine: CHUNK bits per clock, start/done handshake.
// Optional macro SEQ_ADDER_OVERFLOW_EN builds the signed-overflow flag; otherwise overflow is 0.
module seq_chunk_adder #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic clk,
    input  logic reset,
    seq_chunk_adder_if.slave bus
);
    localparam int N  = WIDTH / CHUNK;
    localparam int KW = (N > 1) ? $clog2(N) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(N - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_s;
    logic [WIDTH-1:0] r_res;
    logic             r_c;
    logic             r_busy;
    logic             r_done;
    logic             r_cout;
    logic [KW-1:0]    r_k;

    logic [CHUNK:0]   w_sum;
    logic [WIDTH-1:0] w_s_next;
    logic [WIDTH-1:0] w_a_next;
    logic [WIDTH-1:0] w_b_next;

    // Operands shift right one chunk per cycle, so the active chunk is always the low CHUNK bits.
    assign w_sum = {1'b0, r_a[CHUNK-1:0]} + {1'b0, r_b[CHUNK-1:0]} + {{CHUNK{1'b0}}, r_c};

    generate
        if (CHUNK == WIDTH) begin : g_single
            assign w_s_next = w_sum[CHUNK-1:0];
            assign w_a_next = r_a;
            assign w_b_next = r_b;
        end else begin : g_multi
            assign w_s_next = {w_sum[CHUNK-1:0], r_s[WIDTH-1:CHUNK]};
            assign w_a_next = {{CHUNK{1'b0}}, r_a[WIDTH-1:CHUNK]};
            assign w_b_next = {{CHUNK{1'b0}}, r_b[WIDTH-1:CHUNK]};
        end
    endgenerate

`ifdef SEQ_ADDER_OVERFLOW_EN
    logic r_ovf;
    logic w_ovf;
    // On the last chunk the low CHUNK bits hold the original MSB chunk of A and B.
    assign w_ovf = (r_a[CHUNK-1] == r_b[CHUNK-1]) && (w_sum[CHUNK-1] != r_a[CHUNK-1]);
    assign bus.overflow = r_ovf;
`else
    assign bus.overflow = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_s     <= '0;
            r_res   <= '0;
            r_c     <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_cout  <= 1'b0;
            r_k     <= '0;
`ifdef SEQ_ADDER_OVERFLOW_EN
            r_ovf   <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE, DONE: begin
                    if (bus.start) begin
                        r_a     <= bus.x;
                        r_b     <= bus.sub ? ~bus.y : bus.y;
                        r_c     <= bus.sub ? ~bus.cin : bus.cin;
                        r_s     <= '0;
                        r_k     <= '0;
                        r_busy  <= 1'b1;
                        r_state <= RUN;
                    end else begin
                        r_state <= IDLE;
                    end
                end
                RUN: begin
                    r_a <= w_a_next;
                    r_b <= w_b_next;
                    r_c <= w_sum[CHUNK];
                    r_s <= w_s_next;
                    if (r_k == K_LAST) begin
                        r_res   <= w_s_next;
                        r_cout  <= w_sum[CHUNK];
`ifdef SEQ_ADDER_OVERFLOW_EN
                        r_ovf   <= w_ovf;
`endif
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= DONE;
                    end else begin
                        r_k <= r_k + 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.busy     = r_busy;
    assign bus.done     = r_done;
    assign bus.resadder = r_res;
    assign bus.cout     = r_cout;
endmodule
